// File: rtl/gpr_pc_pkg.sv
// gpr_pc_pkg: shared widths, reset vector and word/index types for the RV32 architectural state.
package gpr_pc_pkg;
    localparam int XLEN = 32;
    localparam int NREG_ADDR_W = 5;
    localparam logic [31:0] RESET_VECTOR = 32'h8000_0000;
    typedef logic [4:0] reg_idx_t;
    typedef logic [31:0] xword_t;
endpackage

// File: rtl/gpr_pc_state_state_reg.sv
// state_reg: enabled register with synchronous active-high reset to RESET_VAL.
module state_reg #(
    parameter int WIDTH = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] dout_d, dout_q;
    always_comb dout_d = wen ? din : dout_q;
    always_ff @(posedge clk) begin
        if (rst) dout_q <= RESET_VAL;
        else dout_q <= dout_d;
    end
    assign dout = dout_q;
endmodule

// File: rtl/gpr_pc_state.sv
// gpr_pc_state: RV32 register file (2R/1W, x0 = 0) plus boot-vectored PC register.
// Define GPR_PC_STATE_BYPASS_EN for write-first forwarding on both read ports.
module gpr_pc_state
    import gpr_pc_pkg::*;
#(
    parameter int ADDR_WIDTH = NREG_ADDR_W,
    parameter int DATA_WIDTH = XLEN,
    parameter logic [DATA_WIDTH-1:0] RESET_PC = RESET_VECTOR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] rs1addr,
    input  logic [ADDR_WIDTH-1:0] rs2addr,
    output logic [DATA_WIDTH-1:0] rs1data,
    output logic [DATA_WIDTH-1:0] rs2data,
    input  logic                  pc_wen,
    input  logic [DATA_WIDTH-1:0] pc_next,
    output logic [DATA_WIDTH-1:0] pc
);
    localparam int NREG = 2 ** ADDR_WIDTH;
    logic [DATA_WIDTH-1:0] regs_d [NREG];
    logic [DATA_WIDTH-1:0] regs_q [NREG];
    logic                  wr_ok;
    assign wr_ok = wen && (waddr != '0);
    always_comb begin
        regs_d = regs_q;
        if (wr_ok) regs_d[waddr] = wdata;
    end
    always_ff @(posedge clk) begin
        if (rst) regs_q <= '{default: '0};
        else regs_q <= regs_d;
    end
`ifdef GPR_PC_STATE_BYPASS_EN
    // rst is sampled too so a write dropped by reset is never forwarded
    always_comb begin
        rs1data = (rs1addr == '0) ? '0 : (wr_ok && !rst && rs1addr == waddr) ? wdata : regs_q[rs1addr];
        rs2data = (rs2addr == '0) ? '0 : (wr_ok && !rst && rs2addr == waddr) ? wdata : regs_q[rs2addr];
    end
`else
    always_comb begin
        rs1data = (rs1addr == '0) ? '0 : regs_q[rs1addr];
        rs2data = (rs2addr == '0) ? '0 : regs_q[rs2addr];
    end
`endif
    state_reg #(
        .WIDTH     (DATA_WIDTH),
        .RESET_VAL (RESET_PC)
    ) u_pc (
        .clk  (clk),
        .rst  (rst),
        .wen  (pc_wen),
        .din  (pc_next),
        .dout (pc)
    );
endmodule

// File: tb/tb_gpr_pc_state.sv
// tb_gpr_pc_state: directed self-checking bench for gpr_pc_state (honours GPR_PC_STATE_BYPASS_EN).
module tb_gpr_pc_state;
    logic        clk = 1'b0;
    logic        rst, wen, pc_wen;
    logic [4:0]  waddr, rs1addr, rs2addr;
    logic [31:0] wdata, pc_next, rs1data, rs2data, pc;
    int          n_cmp = 0;
    int          n_bad = 0;

    gpr_pc_state dut (
        .clk     (clk),
        .rst     (rst),
        .wen     (wen),
        .waddr   (waddr),
        .wdata   (wdata),
        .rs1addr (rs1addr),
        .rs2addr (rs2addr),
        .rs1data (rs1data),
        .rs2data (rs2data),
        .pc_wen  (pc_wen),
        .pc_next (pc_next),
        .pc      (pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; wen = 1'b0; pc_wen = 1'b0;
        waddr = '0; wdata = '0; rs1addr = '0; rs2addr = '0; pc_next = '0;
        tick();
        rst = 1'b0;
        #1;
        check("reset_pc", pc, 32'h8000_0000);
        for (int i = 0; i < 32; i++) begin
            rs1addr = 5'(i); rs2addr = 5'(31 - i);
            #1;
            check($sformatf("reset_rs1_x%0d", i), rs1data, 32'h0);
            check($sformatf("reset_rs2_x%0d", 31 - i), rs2data, 32'h0);
        end
        wen = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
        tick();
        wen = 1'b0; rs1addr = 5'd5; rs2addr = 5'd5;
        #1;
        check("wr5_rs1", rs1data, 32'hDEAD_BEEF);
        check("wr5_rs2", rs2data, 32'hDEAD_BEEF);
        rs1addr = 5'd6;
        #1;
        check("x6_untouched", rs1data, 32'h0);
        waddr = 5'd5; wdata = 32'h0;
        tick();
        check("wen0_holds_x5", rs2data, 32'hDEAD_BEEF);
        wen = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
        tick();
        wen = 1'b0; rs1addr = 5'd0; rs2addr = 5'd0;
        #1;
        check("x0_rs1_zero", rs1data, 32'h0);
        check("x0_rs2_zero", rs2data, 32'h0);
        wen = 1'b1; waddr = 5'd7; wdata = 32'h1234; rs1addr = 5'd7; rs2addr = 5'd5;
        #1;
`ifdef GPR_PC_STATE_BYPASS_EN
        check("same_cycle_x7", rs1data, 32'h1234);
`else
        check("same_cycle_x7", rs1data, 32'h0);
`endif
        check("same_cycle_other_port", rs2data, 32'hDEAD_BEEF);
        tick();
        wen = 1'b0;
        #1;
        check("after_edge_x7", rs1data, 32'h1234);
        pc_wen = 1'b1; pc_next = 32'h8000_0004;
        tick();
        check("pc_update", pc, 32'h8000_0004);
        pc_wen = 1'b0; pc_next = 32'h0;
        tick();
        check("pc_hold", pc, 32'h8000_0004);
        pc_wen = 1'b1; pc_next = 32'hFFFF_FFFE;
        tick();
        check("pc_verbatim", pc, 32'hFFFF_FFFE);
        pc_wen = 1'b0;
        wen = 1'b1; waddr = 5'd3; wdata = 32'h77; rs1addr = 5'd3; rs2addr = 5'd31;
        tick();
        check("x3_written", rs1data, 32'h77);
        waddr = 5'd31; wdata = 32'hA5A5_5A5A;
        tick();
        check("x31_written", rs2data, 32'hA5A5_5A5A);
        rst = 1'b1; wen = 1'b1; waddr = 5'd3; wdata = 32'h55; pc_wen = 1'b1; pc_next = 32'h100;
        tick();
        rst = 1'b0; wen = 1'b0; pc_wen = 1'b0;
        #1;
        check("rst_prio_x3", rs1data, 32'h0);
        check("rst_prio_x31", rs2data, 32'h0);
        check("rst_prio_pc", pc, 32'h8000_0000);
        rs1addr = 5'd5; rs2addr = 5'd7;
        #1;
        check("rst_clears_x5", rs1data, 32'h0);
        check("rst_clears_x7", rs2data, 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/gpr_pc_state.md
Name: gpr_pc_state

Overview:
- Architectural state block for the single-cycle RV32 core.
- Holds the general-purpose register file: 2 combinational read ports, 1 synchronous write port, x0 hardwired to zero.
- Holds the program-counter register, which resets to the boot address.
- Sits between the decode stage (register addresses), the writeback path (rd data) and the next-PC logic (pc_next).

Parameters:
- ADDR_WIDTH, 5, register-index width; the file has 2**ADDR_WIDTH entries.
- DATA_WIDTH, 32, register and PC width.
- RESET_PC, 32'h8000_0000, PC value loaded on reset.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- wen  input  1  GPR write enable.
- waddr  input  ADDR_WIDTH  GPR write index (rd).
- wdata  input  DATA_WIDTH  GPR write data.
- rs1addr  input  ADDR_WIDTH  read port 1 index.
- rs2addr  input  ADDR_WIDTH  read port 2 index.
- rs1data  output  DATA_WIDTH  read port 1 data, combinational.
- rs2data  output  DATA_WIDTH  read port 2 data, combinational.
- pc_wen  input  1  PC update enable.
- pc_next  input  DATA_WIDTH  next PC value.
- pc  output  DATA_WIDTH  current PC, registered.

Behaviour:
- Reset: synchronous, active-high, sampled at posedge clk. While rst=1 at a posedge:
  - all GPR entries are cleared to 0;
  - pc is loaded with RESET_PC.
- Reset takes priority over wen and pc_wen in the same cycle; the write is dropped.
- Outputs after reset: pc=RESET_PC; rs1data/rs2data=0 for every address.
- Before the first reset edge, state is undefined; the bench must assert rst for at least 1 cycle.
- GPR write: at posedge, if rst=0, wen=1 and waddr!=0, then entry[waddr] <= wdata. Otherwise the file is unchanged.
- x0: writes to index 0 are ignored. Reads of index 0 return 0, independent of stored contents.
- Reads: rsNdata = entry[rsNaddr], purely combinational, zero-cycle latency.
  - Without the optional bypass, a read of the address written this cycle returns the old value until the posedge.
  - Both ports may read the same address at the same time.
- PC: at posedge, if rst=0 and pc_wen=1, then pc <= pc_next; if pc_wen=0, pc holds.
  - No alignment checks; full DATA_WIDTH value stored.
  - Wrap-around is the caller's arithmetic; the block stores pc_next verbatim.
- Reset mid-operation: the next posedge with rst=1 restores the reset state regardless of pending writes.
- No handshake; no internal state machine.

Optional Feature:
- Macro: GPR_PC_STATE_BYPASS_EN.
- Defined: write-first forwarding on each read port independently. If wen=1, rst=0, waddr!=0 and rsNaddr==waddr, then rsNdata = wdata combinationally in the same cycle. x0 still reads 0.
- Undefined: no forwarding; reads return stored contents only, as above.

Decomposition:
- Shared package gpr_pc_pkg holds:
  - constants XLEN=32, NREG_ADDR_W=5, RESET_VECTOR=32'h8000_0000;
  - typedefs reg_idx_t [4:0] and xword_t [31:0].
- One natural sub-module: state_reg (parameters WIDTH, RESET_VAL; ports clk, rst, wen, din, dout) with synchronous reset-to-RESET_VAL and enable.
  - Used once for pc.
  - May be used per GPR entry, or the file is a single array.

Test Plan:
- Reset: rst=1 for 1 cycle then 0 -> pc=32'h8000_0000; rs1data=rs2data=0 for addresses 0..31.
- Write/read: wen=1, waddr=5, wdata=32'hDEAD_BEEF; next cycle rs1addr=5, rs2addr=5 -> both read 32'hDEAD_BEEF. Address 6 still reads 0.
- x0 protection: wen=1, waddr=0, wdata=32'hFFFF_FFFF -> rs1addr=0 reads 0 after the edge.
- Same-cycle read of written address: waddr=rs1addr=7, wdata=32'h1234 with entry 7 holding 0 ->
  - before the edge, rs1data=0 without the bypass macro and 32'h1234 with it;
  - after the edge, 32'h1234 in both cases.
- PC: pc_wen=1, pc_next=32'h8000_0004 -> pc=32'h8000_0004 after 1 edge. pc_wen=0 with pc_next=32'h0 -> pc holds 32'h8000_0004.
- Reset priority: rst=1 with wen=1, waddr=3, wdata=32'h55, pc_wen=1, pc_next=32'h100 -> after the edge reg3=0 and pc=32'h8000_0000.
